// File: rtl/pu_pkg.sv
// Shared definitions for the PU fetch path: widths, fixed instruction encodings,
// the fetch-state enum and small arithmetic helpers. PU_SSTEP_EN adds the SWAIT state.
package pu_pkg;

  localparam int PC_W   = 8;
  localparam int INSN_W = 16;
  localparam int ICNT_W = 16;

  localparam logic [INSN_W-1:0] NOP_INSN  = 16'h0000;
  localparam logic [INSN_W-1:0] HALT_INSN = 16'h0001;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_HALT
`ifdef PU_SSTEP_EN
    ,
    ST_SWAIT
`endif
  } fetch_state_e;

  // pc wraps silently modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
    return a + PC_W'(1);
  endfunction

  function automatic logic [ICNT_W-1:0] icnt_sat_inc(input logic [ICNT_W-1:0] a);
    return (a == {ICNT_W{1'b1}}) ? a : a + ICNT_W'(1);
  endfunction

endpackage

// File: rtl/pu_fetch.sv
// Instruction fetch FSM for the PU: fills from a 1-cycle synchronous imem, runs,
// halts on decoder request and resumes on go. PU_SSTEP_EN adds single-step mode.
module pu_fetch
  import pu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              h,
  input  logic              go,
`ifdef PU_SSTEP_EN
  input  logic              sstep,
  input  logic              step,
`endif
  output logic [INSN_W-1:0] o,
  output logic [PC_W-1:0]   pc,
  output logic              valid,
  output logic              halted,
  output logic [ICNT_W-1:0] icnt
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;

  // Outputs are decoded from state and pc so that reset forces them at once.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned and a latch is never inferred.
    state_d   = state_q;
    pc_d      = pc_q;
    imem_addr = pc_q;
    o         = NOP_INSN;
    valid     = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_FILL: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        o     = imem_rdata;
        valid = 1'b1;
        if (h) begin
          // Halt wins over go and sstep; pc stays on the halting instruction.
          state_d = ST_HALT;
        end else begin
          pc_d      = pc_inc(pc_q);
          imem_addr = pc_d;
`ifdef PU_SSTEP_EN
          if (sstep) state_d = ST_SWAIT;
`endif
        end
      end

      ST_HALT: begin
        o      = HALT_INSN;
        halted = 1'b1;
        if (go) begin
          pc_d    = pc_inc(pc_q);
          state_d = ST_FILL;
        end
      end

`ifdef PU_SSTEP_EN
      ST_SWAIT: begin
        // imem_addr already holds pc, so the word is ready when RUN is entered.
        if (step || !sstep) state_d = ST_RUN;
      end
`endif

      default: begin
        state_d = ST_FILL;
      end
    endcase

    icnt_d = valid ? icnt_sat_inc(icnt_q) : icnt_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      pc_q    <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icnt_q  <= icnt_d;
    end
  end

  assign pc   = pc_q;
  assign icnt = icnt_q;

endmodule

// File: tb/tb_pu_fetch.sv
// Self-checking bench for pu_fetch: directed table, wrap/saturation run, reset
// cases, randomized run against a behavioural model, and single-step when PU_SSTEP_EN.
module tb_pu_fetch;
  import pu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_rdata;
  logic              h = 1'b0;
  logic              go = 1'b0;
`ifdef PU_SSTEP_EN
  logic              sstep = 1'b0;
  logic              step = 1'b0;
`endif
  logic [INSN_W-1:0] o;
  logic [PC_W-1:0]   pc;
  logic              valid;
  logic              halted;
  logic [ICNT_W-1:0] icnt;

  logic [INSN_W-1:0] mem [256];

  int n_vec  = 0;
  int n_fail = 0;

  pu_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .h         (h),
    .go        (go),
`ifdef PU_SSTEP_EN
    .sstep     (sstep),
    .step      (step),
`endif
    .o         (o),
    .pc        (pc),
    .valid     (valid),
    .halted    (halted),
    .icnt      (icnt)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address appears next cycle.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        h;
    logic        go;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] o;
    logic        halted;
    logic [7:0]  addr;
    logic [15:0] icnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    h = 1'b0;
    go = 1'b0;
`ifdef PU_SSTEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Behavioural model state: phase of the fetcher, pc and valid-cycle count.
  localparam int P_FILL = 0, P_RUN = 1, P_HALT = 2, P_SWAIT = 3;
  int m_phase, m_pc, m_icnt;

  vec_t tbl [11];

  initial begin
    int ss, st;
    logic        e_valid, e_halted;
    logic [15:0] e_o;
    int          e_addr;

    // ---------------- directed table: fetch, halt, resume, go/h corners
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 1'b0, 8'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'd0, 16'h0400, 1'b0, 8'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'd1, 16'h0501, 1'b0, 8'd2, 16'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd2, 16'h0001, 1'b0, 8'd2, 16'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd2, 16'h0001, 1'b1, 8'd2, 16'd3};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd2, 16'h0001, 1'b1, 8'd2, 16'd3};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'd3, 16'h0000, 1'b0, 8'd3, 16'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'd3, 16'h0A0B, 1'b0, 8'd4, 16'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'd4, 16'h1234, 1'b0, 8'd5, 16'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'd5, 16'h5555, 1'b0, 8'd5, 16'd5};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'd5, 16'h0001, 1'b1, 8'd5, 16'd6};

    clear_mem();
    mem[0] = 16'h0400; mem[1] = 16'h0501; mem[2] = 16'h0001;
    mem[3] = 16'h0A0B; mem[4] = 16'h1234; mem[5] = 16'h5555;

    #1;
    check("reset_valid", valid, 1'b0);
    check("reset_pc", pc, 8'd0);
    check("reset_o", o, 16'h0000);
    check("reset_halted", halted, 1'b0);
    check("reset_addr", imem_addr, 8'd0);
    check("reset_icnt", icnt, 16'd0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      h  = tbl[i].h;
      go = tbl[i].go;
      #1;
      check($sformatf("tbl%0d_valid", i), valid, tbl[i].valid);
      check($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("tbl%0d_o", i), o, tbl[i].o);
      check($sformatf("tbl%0d_halted", i), halted, tbl[i].halted);
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("tbl%0d_icnt", i), icnt, tbl[i].icnt);
      @(negedge clk);
    end
    h = 1'b0; go = 1'b0;

    // ---------------- reset asserted in HALT
    rst_n = 1'b0;
    #1;
    check("rsthalt_halted", halted, 1'b0);
    check("rsthalt_pc", pc, 8'd0);
    check("rsthalt_o", o, 16'h0000);
    check("rsthalt_icnt", icnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rsthalt_fill_valid", valid, 1'b0);
    @(negedge clk);
    #1;
    check("rsthalt_run_valid", valid, 1'b1);
    check("rsthalt_run_o", o, 16'h0400);

    // ---------------- reset asserted mid-RUN at pc=5
    for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
    do_reset();
    repeat (6) @(negedge clk);
    #1;
    check("rstrun_pre_pc", pc, 8'd5);
    check("rstrun_pre_valid", valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstrun_o", o, 16'h0000);
    check("rstrun_pc", pc, 8'd0);
    check("rstrun_valid", valid, 1'b0);
    check("rstrun_addr", imem_addr, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstrun_fill_valid", valid, 1'b0);
    @(negedge clk);
    #1;
    check("rstrun_first_valid", valid, 1'b1);
    check("rstrun_first_pc", pc, 8'd0);
    check("rstrun_first_o", o, 16'h2000);

    // ---------------- NOP run: pc wrap and icnt saturation
    clear_mem();
    do_reset();
    for (int k = 0; k < 65539; k++) begin
      #1;
      if (k == 255) begin
        check("wrap_pc_fe", pc, 8'hFE); check("wrap_v_fe", valid, 1'b1);
      end
      if (k == 256) begin
        check("wrap_pc_ff", pc, 8'hFF); check("wrap_v_ff", valid, 1'b1);
      end
      if (k == 257) begin
        check("wrap_pc_00", pc, 8'h00); check("wrap_v_00", valid, 1'b1);
      end
      if (k == 65535) check("icnt_fffe", icnt, 16'hFFFE);
      if (k >= 65536) check($sformatf("icnt_sat_%0d", k - 65536), icnt, 16'hFFFF);
      @(negedge clk);
    end

`ifdef PU_SSTEP_EN
    // ---------------- single-step: step pulses 4 cycles apart
    for (int i = 0; i < 256; i++) mem[i] = 16'h3000 + 16'(i);
    sstep = 1'b1;
    do_reset();
    @(negedge clk);
    #1;
    check("ss_first_valid", valid, 1'b1);
    check("ss_first_pc", pc, 8'd0);
    @(negedge clk);
    for (int s = 1; s <= 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        #1;
        check($sformatf("ss%0d_wait_valid", s), valid, 1'b0);
        check($sformatf("ss%0d_wait_addr", s), imem_addr, 8'(s));
        @(negedge clk);
      end
      step = 1'b1;
      #1;
      check($sformatf("ss%0d_step_valid", s), valid, 1'b0);
      @(negedge clk);
      step = 1'b0;
      #1;
      check($sformatf("ss%0d_run_valid", s), valid, 1'b1);
      check($sformatf("ss%0d_run_pc", s), pc, 8'(s));
      check($sformatf("ss%0d_run_o", s), o, 16'h3000 + 16'(s));
      @(negedge clk);
    end
    sstep = 1'b0;
`endif

    // ---------------- randomized run against the behavioural model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    m_phase = P_FILL; m_pc = 0; m_icnt = 0;
    for (int c = 0; c < 3000; c++) begin
      h  = ($urandom_range(0, 3) == 0);
      go = ($urandom_range(0, 2) == 0);
      ss = 0; st = 0;
`ifdef PU_SSTEP_EN
      ss = ($urandom_range(0, 3) != 0) ? 1 : 0;
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sstep = ss[0];
      step  = st[0];
`endif
      #1;
      e_valid  = (m_phase == P_RUN);
      e_halted = (m_phase == P_HALT);
      e_o      = (m_phase == P_RUN)  ? mem[m_pc] :
                 (m_phase == P_HALT) ? 16'h0001 : 16'h0000;
      e_addr   = (m_phase == P_RUN && !h) ? (m_pc + 1) % 256 : m_pc;
      check("rnd_valid", valid, e_valid);
      check("rnd_pc", pc, m_pc);
      check("rnd_o", o, e_o);
      check("rnd_halted", halted, e_halted);
      check("rnd_addr", imem_addr, e_addr);
      check("rnd_icnt", icnt, m_icnt);

      if (e_valid && m_icnt < 65535) m_icnt++;
      case (m_phase)
        P_FILL: m_phase = P_RUN;
        P_RUN: begin
          if (h) m_phase = P_HALT;
          else begin
            m_pc = (m_pc + 1) % 256;
            m_phase = (ss != 0) ? P_SWAIT : P_RUN;
          end
        end
        P_HALT: if (go) begin m_pc = (m_pc + 1) % 256; m_phase = P_FILL; end
        default: if (st != 0 || ss == 0) m_phase = P_RUN;
      endcase
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_fetch.md
PU_FETCH -- requirements
Module: pu_fetch

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: an asynchronous, active-low reset.
REQ-003 The block SHALL have the port imem_addr, output, PC_W bits: the instruction-memory read address (synchronous memory, data valid the cycle after the address).
REQ-004 The block SHALL have the port imem_rdata, input, INSN_W bits: the instruction word returned for the previous cycle's imem_addr.
REQ-005 The block SHALL have the port h, input, 1 bit: the halt indication from the decoder for the current o.
REQ-006 The block SHALL have the port go, input, 1 bit: a one-cycle resume pulse, honoured only in HALT.
REQ-007 The block SHALL have the port o, output, INSN_W bits: the instruction presented to the decoder.
REQ-008 The block SHALL have the port pc, output, PC_W bits: the address of the instruction currently on o.
REQ-009 The block SHALL have the port valid, output, 1 bit: o carries a real fetched instruction this cycle.
REQ-010 The block SHALL have the port halted, output, 1 bit: high while the FSM is in HALT.
REQ-011 The block SHALL have the port icnt, output, 16 bits: the count of valid cycles, saturating.
REQ-012 The block SHALL have the ports sstep (input, 1 bit: single-step mode level) and step (input, 1 bit: advance pulse), present only with PU_SSTEP_EN.

Function
REQ-013 The block SHALL implement the states FILL, RUN, HALT and, with PU_SSTEP_EN only, SWAIT.
REQ-014 In FILL, the block SHALL drive imem_addr=pc, o=NOP, valid=0, and move to RUN next cycle.
REQ-015 In RUN, the block SHALL drive o=imem_rdata, valid=1 and imem_addr=pc+1, and update pc<=pc+1 unless halting.
REQ-016 pc arithmetic SHALL be modulo 2^PC_W, so pc=8'hFF increments to 8'h00 with no flag raised.
REQ-017 In RUN with h=1, the block SHALL move to HALT next cycle, hold pc unchanged and drive imem_addr=pc.
REQ-018 In HALT, the block SHALL drive o=HALT_INSN (16'h0001), valid=0, halted=1 and imem_addr=pc.
REQ-019 In HALT, go=1 SHALL set pc<=pc+1 and move the FSM to FILL, so the first post-resume instruction appears 2 cycles after go.
REQ-020 go outside HALT SHALL be ignored, and h together with go in RUN SHALL give HALT with go discarded.
REQ-021 icnt SHALL increment on every valid=1 cycle and saturate at 16'hFFFF.
REQ-022 The fetch latency SHALL be 1 cycle from reset release to the first valid instruction (address 0).

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state=FILL, pc=0, icnt=0, o=NOP, valid=0, halted=0 and imem_addr=0.
REQ-024 Reset asserted mid-RUN or mid-HALT SHALL abandon the in-flight fetch, and no instruction SHALL be presented until FILL completes after release.

Configuration
REQ-025 With PU_SSTEP_EN defined and sstep=1, RUN SHALL last exactly one cycle, then go to SWAIT with pc already incremented.
REQ-026 In SWAIT, the block SHALL drive o=NOP, valid=0 and imem_addr=pc, and a step pulse SHALL move it to RUN.
REQ-027 In SWAIT, sstep=0 SHALL move the FSM to RUN and resume free-running.
REQ-028 Without PU_SSTEP_EN, the sstep and step ports, SWAIT and all related logic SHALL be absent, leaving behaviour per REQ-013 to REQ-024.

Structure
REQ-029 The shared package pu_pkg SHALL hold PC_W=8, INSN_W=16, NOP_INSN=16'h0000, HALT_INSN=16'h0001 and the fetch-state enum.
REQ-030 pu_fetch SHALL be a single module with no sub-module, as the FSM, pc and icnt are tightly coupled.

Verification
REQ-031 Reset release with imem holding 0400,0501,0001: the bench SHALL see valid cycles with pc=0,1,2, then h gives halted=1, pc=2, o=0001, icnt=3.
REQ-032 HALT at pc=2, pulse go: the bench SHALL see the next cycle FILL with imem_addr=3, then o=mem[3], valid=1, pc=3.
REQ-033 The bench SHALL preload NOPs and run from pc=8'hFE, and SHALL see pc=FE,FF,00 on consecutive valid cycles.
REQ-034 The bench SHALL assert rst_n=0 at pc=5 mid-RUN, and SHALL see o=0000, pc=0 and valid=0 immediately, with pc=0 valid 1 cycle after release.
REQ-035 With PU_SSTEP_EN and sstep=1, the bench SHALL issue step pulses 4 cycles apart, and SHALL see each valid exactly 1 cycle per step with pc advancing by 1.
REQ-036 The bench SHALL force icnt=16'hFFFE and run 3 valid cycles, and SHALL see icnt=16'hFFFF held.
